// File: rtl/hci_core_mux_static_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hci_core_mux_static_ctrl: ownership, select and outstanding-count control |
// | for a static HCI core mux.                              Revision: 1.0    |
// +--------------------------------------------------------------------------+
module hci_core_mux_static_ctrl #(
  parameter int NB_CHAN         = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int WRITE_RESP      = 0,
  localparam int SEL_W = $clog2(NB_CHAN-1)+1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NB_CHAN-1:0] own_req_i,
  output logic [NB_CHAN-1:0] own_gnt_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               issue_en_o,
  input  logic               out_req_i,
  input  logic               out_gnt_i,
  input  logic               out_wen_i,
  input  logic               out_r_valid_i,
  input  logic               out_r_ready_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(NB_CHAN-1);
  localparam logic             COUNT_WR  = (WRITE_RESP != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   rr_ptr;

  logic               owner_req;
  logic               win_any;
  logic               hi_found;
  logic [SEL_W-1:0]   hi_idx;
  logic [SEL_W-1:0]   lo_idx;
  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W-1:0]   rr_next;
  logic [NB_CHAN-1:0] win_oh;
  logic               inc;
  logic               dec;
  logic               cnt_zero;
  logic               cnt_full;

  always_comb begin
    owner_req = 1'b0;
    for (int k = 0; k < NB_CHAN; k++) begin
      if (sel_o == SEL_W'(k)) owner_req = own_req_i[k];
    end
  end

  // Descending scan so the lowest matching index wins: hi_idx is the first
  // request at/after rr_ptr, lo_idx the first overall (used on wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NB_CHAN-1; k >= 0; k--) begin
      if (own_req_i[k]) begin
        lo_idx = SEL_W'(k);
        if (SEL_W'(k) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(k);
        end
      end
    end
    win_any = |own_req_i;
    win_idx = hi_found ? hi_idx : lo_idx;
    rr_next = (win_idx == LAST_CHAN) ? '0 : win_idx + SEL_W'(1);
    for (int k = 0; k < NB_CHAN; k++) begin
      win_oh[k] = (win_idx == SEL_W'(k));
    end
  end

  assign inc      = out_req_i & out_gnt_i & (out_wen_i | COUNT_WR);
  assign dec      = out_r_valid_i & out_r_ready_i;
  assign cnt_zero = (cnt == '0);
  assign cnt_full = (cnt == CNT_MAX);

  assign issue_en_o = (state == OWNED) & ~cnt_full & owner_req;
  assign busy_o     = (state != IDLE) | ~cnt_zero;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sel_o     <= '0;
      own_gnt_o <= '0;
      cnt       <= '0;
      rr_ptr    <= '0;
      err_o     <= 1'b0;
    end else begin
      if ((out_req_i && state != OWNED) || (dec && cnt_zero) ||
          (inc && !dec && cnt_full)) begin
        err_o <= 1'b1;
      end

      // Saturating count; simultaneous issue and return cancel out.
      if (inc && !dec && !cnt_full) begin
        cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc && !cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (win_any) begin
            state     <= OWNED;
            sel_o     <= win_idx;
            own_gnt_o <= win_oh;
            rr_ptr    <= rr_next;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            own_gnt_o <= '0;
            state     <= (cnt_zero && !dec) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_zero) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          own_gnt_o <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hci_core_mux_static_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hci_core_mux_static_ctrl: reference-model bench for the mux ctrl.     |
// |                                                         Revision: 1.0    |
// +--------------------------------------------------------------------------+
module tb_hci_core_mux_static_ctrl;

  localparam int NB    = 4;
  localparam int MAXO  = 3;
  localparam int WRESP = 0;
  localparam int SEL_W = $clog2(NB-1)+1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NB-1:0]    own_req = '0;
  logic [NB-1:0]    own_gnt;
  logic [SEL_W-1:0] sel;
  logic             issue_en;
  logic             out_req = 1'b0;
  logic             out_gnt = 1'b0;
  logic             out_wen = 1'b0;
  logic             rv = 1'b0;
  logic             rr = 1'b0;
  logic             busy;
  logic             err;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  hci_core_mux_static_ctrl #(
    .NB_CHAN(NB), .MAX_OUTSTANDING(MAXO), .WRITE_RESP(WRESP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .own_req_i(own_req), .own_gnt_o(own_gnt),
    .sel_o(sel), .issue_en_o(issue_en), .out_req_i(out_req), .out_gnt_i(out_gnt),
    .out_wen_i(out_wen), .out_r_valid_i(rv), .out_r_ready_i(rr),
    .busy_o(busy), .err_o(err)
  );

  // Reference model: phase 0 = nobody owns, 1 = owned, 2 = waiting for returns.
  int m_ph = 0, m_owner = 0, m_rr = 0, m_cnt = 0, m_old = 0, m_w = 0;
  bit m_err = 1'b0, m_inc, m_dec, m_found;

  always @(posedge clk) begin
    m_inc = out_req && out_gnt && (out_wen || WRESP != 0);
    m_dec = rv && rr;
    if (rst) begin
      m_ph = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      if ((out_req && m_ph != 1) || (m_dec && m_cnt == 0) ||
          (m_inc && !m_dec && m_cnt == MAXO)) m_err = 1'b1;
      m_old = m_cnt;
      if (m_inc && !m_dec) m_cnt = (m_cnt + 1 > MAXO) ? MAXO : m_cnt + 1;
      else if (m_dec && !m_inc) m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
      if (m_ph == 0) begin
        m_found = 1'b0;
        for (int i = 0; i < NB; i++) begin
          m_w = (m_rr + i) % NB;
          if (!m_found && own_req[m_w]) begin
            m_found = 1'b1; m_owner = m_w; m_rr = (m_w + 1) % NB; m_ph = 1;
          end
        end
      end else if (m_ph == 1) begin
        if (!own_req[m_owner]) m_ph = (m_old == 0 && !m_dec) ? 0 : 2;
      end else begin
        if (m_old == 0) m_ph = 0;
      end
    end
  end

  function automatic bit model_issue();
    return (m_ph == 1) && (m_cnt < MAXO) && own_req[m_owner];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_gnt", int'(own_gnt), (m_ph == 1) ? (1 << m_owner) : 0);
      chk("mon_sel", int'(sel), m_owner);
      chk("mon_issue", int'(issue_en), int'(model_issue()));
      chk("mon_busy", int'(busy), int'(m_ph != 0 || m_cnt != 0));
      chk("mon_err", int'(err), int'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_bus();
    out_req = 1'b0; out_gnt = 1'b0; out_wen = 1'b0; rv = 1'b0; rr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; own_req = '0; idle_bus();
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic issue_reads(input int n);
    out_req = 1'b1; out_gnt = 1'b1; out_wen = 1'b1;
    repeat (n) cyc();
    idle_bus();
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    // reset state
    do_reset();
    mon_en = 1'b1;
    chk("t1_gnt", int'(own_gnt), 0);
    chk("t1_sel", int'(sel), 0);
    chk("t1_issue", int'(issue_en), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_err", int'(err), 0);

    // grant latency
    own_req = 4'b0100;
    cyc();
    chk("t2_gnt", int'(own_gnt), 4);
    chk("t2_sel", int'(sel), 2);
    chk("t2_issue", int'(issue_en), 1);

    // drain before handover
    do_reset();
    own_req = 4'b0001;
    cyc();
    chk("t3_sel0", int'(sel), 0);
    issue_reads(3);
    chk("t3_full_issue", int'(issue_en), 0);
    own_req = 4'b0000;
    cyc();
    chk("t3_drain_gnt", int'(own_gnt), 0);
    chk("t3_drain_issue", int'(issue_en), 0);
    chk("t3_drain_busy", int'(busy), 1);
    rv = 1'b1; rr = 1'b1;
    repeat (3) cyc();
    idle_bus();
    chk("t3_cnt0_busy", int'(busy), 1);
    chk("t3_sel_held", int'(sel), 0);
    cyc();
    chk("t3_idle_busy", int'(busy), 0);
    own_req = 4'b0010;
    cyc();
    chk("t3_next_sel", int'(sel), 1);
    chk("t3_next_gnt", int'(own_gnt), 2);
    chk("t3_err", int'(err), 0);

    // round-robin order
    do_reset();
    own_req = 4'b1111;
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("t4_order", int'(sel), exp_order[k]);
      issue_reads(1);
      own_req = 4'b1111 & ~(4'b0001 << (k % NB));
      cyc();
      rv = 1'b1; rr = 1'b1;
      cyc();
      idle_bus();
      own_req = 4'b1111;
      cyc(); cyc();
    end

    // outstanding limit, simultaneous issue/return, writes not counted
    do_reset();
    own_req = 4'b0001;
    cyc();
    issue_reads(3);
    chk("t5_limit_issue", int'(issue_en), 0);
    out_req = 1'b1; out_gnt = 1'b1; out_wen = 1'b1; rv = 1'b1; rr = 1'b1;
    cyc();
    idle_bus();
    chk("t5_incdec_issue", int'(issue_en), 0);
    chk("t5_incdec_err", int'(err), 0);
    rv = 1'b1; rr = 1'b1;
    cyc();
    idle_bus();
    chk("t5_dec_issue", int'(issue_en), 1);
    out_req = 1'b1; out_gnt = 1'b1; out_wen = 1'b0;
    cyc();
    idle_bus();
    chk("t5_write_issue", int'(issue_en), 1);

    // error conditions
    do_reset();
    out_req = 1'b1;
    cyc();
    out_req = 1'b0;
    chk("t6_req_idle_err", int'(err), 1);
    cyc(); cyc();
    chk("t6_sticky_err", int'(err), 1);
    do_reset();
    chk("t6_reset_err", int'(err), 0);
    rv = 1'b1; rr = 1'b1;
    cyc();
    idle_bus();
    chk("t6_underflow_err", int'(err), 1);
    do_reset();
    own_req = 4'b0001;
    cyc();
    issue_reads(3);
    out_req = 1'b1; out_gnt = 1'b1; out_wen = 1'b1;
    cyc();
    idle_bus();
    chk("t6_overflow_err", int'(err), 1);
    do_reset();
    own_req = 4'b0001;
    cyc();
    issue_reads(2);
    own_req = 4'b0000;
    cyc();
    chk("t6_drain_busy", int'(busy), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_err", int'(err), 0);
    chk("t6_rst_gnt", int'(own_gnt), 0);
    chk("t6_rst_sel", int'(sel), 0);

    // randomized legal traffic with occasional resets
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(0, 7) == 0) own_req[k] = ~own_req[k];
      end
      out_req = model_issue() && ($urandom_range(0, 1) == 1);
      out_gnt = ($urandom_range(0, 3) != 0);
      out_wen = ($urandom_range(0, 3) != 0);
      rv      = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      rr      = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1'b0;
    idle_bus();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
